uart_rx_deser: RTL and testbench

UART receive deserializer: the receive end of the team's UART link, pairing with the transmitter that drives TX.
- Samples the incoming RX line with a configurable oversampling clock.
- Validates start, parity and stop bits; presents each received word on a valid/ready holding register.
- Drives RTS for hardware flow control.
- Sits between the RX pad (via its own synchronizer) and the byte-consuming logic.

---
 rtl/uart_rx_deser.sv | 207 ++++++++++++++++++++
 tb/tb_uart_rx_deser.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: oversampled start/data/parity/stop capture into a valid/ready holding register.
// Word visible 1 clk after the stop-bit sample; a full, unconsumed holding register drops the new word and pulses overrun_o.
module uart_rx_deser #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RX,
    input  logic [19:0]           baud_rate,
    input  logic                  parity_en,
    input  logic                  parity_odd,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_valid_o,
    input  logic                  data_ready_i,
    output logic                  frame_err_o,
    output logic                  parity_err_o,
    output logic                  overrun_o,
    output logic                  RTS,
    output logic                  busy_o
);

    localparam int SCW = $clog2(OVERSAMPLE);
    localparam int BCW = $clog2(DATA_WIDTH + 1);
    localparam logic [SCW-1:0] SC_HALF  = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] SC_LAST  = SCW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q, state_d;
    logic                  rx_meta_q, rx_s_q;
    logic                  armed_q, armed_d;
    logic [19:0]           baud_q, baud_d;
    logic                  par_en_q, par_en_d;
    logic                  par_odd_q, par_odd_d;
    logic [19:0]           tick_cnt_q, tick_cnt_d;
    logic [SCW-1:0]        sample_q, sample_d;
    logic [BCW-1:0]        bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  perr_q, perr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  ferr_q, ferr_d;
    logic                  perr_out_q, perr_out_d;
    logic                  ovr_q, ovr_d;
    logic                  rts_q, rts_d;
    logic                  done;
    logic                  tick;
    logic [19:0]           baud_eff;

    assign baud_eff = (baud_q == 20'd0) ? 20'd1 : baud_q;
    assign tick     = (tick_cnt_q == baud_eff - 20'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            armed_q    <= 1'b1;
            baud_q     <= 20'd1;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            tick_cnt_q <= '0;
            sample_q   <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            perr_out_q <= 1'b0;
            ovr_q      <= 1'b0;
            rts_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            baud_q     <= baud_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            tick_cnt_q <= tick_cnt_d;
            sample_q   <= sample_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            perr_out_q <= perr_out_d;
            ovr_q      <= ovr_d;
            rts_q      <= rts_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q | rx_s_q;
        baud_d     = baud_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        tick_cnt_d = '0;
        sample_d   = sample_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        data_d     = data_q;
        valid_d    = valid_q;
        ferr_d     = ferr_q;
        perr_out_d = perr_out_q;
        ovr_d      = 1'b0;
        done       = 1'b0;

        if (valid_q && data_ready_i) valid_d = 1'b0;
        if (state_q != IDLE) tick_cnt_d = tick ? 20'd0 : tick_cnt_q + 20'd1;

        case (state_q)
            IDLE: begin
                if (armed_q && !rx_s_q) begin
                    state_d   = START;
                    sample_d  = '0;
                    perr_d    = 1'b0;
                    baud_d    = baud_rate;
                    par_en_d  = parity_en;
                    par_odd_d = parity_odd;
                end
            end
            START: begin
                if (tick) begin
                    if (sample_q == SC_HALF) begin
                        sample_d = '0;
                        bit_d    = '0;
                        state_d  = rx_s_q ? IDLE : DATA;
                    end else begin
                        sample_d = sample_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (sample_q == SC_LAST) begin
                        sample_d = '0;
                        shift_d  = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
                        if (bit_q == BIT_LAST) state_d = par_en_q ? PARITY : STOP;
                        else                   bit_d   = bit_q + 1'b1;
                    end else begin
                        sample_d = sample_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    if (sample_q == SC_LAST) begin
                        sample_d = '0;
                        perr_d   = (^shift_q) ^ rx_s_q ^ par_odd_q;
                        state_d  = STOP;
                    end else begin
                        sample_d = sample_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (sample_q == SC_LAST) begin
                        sample_d = '0;
                        state_d  = IDLE;
                        done     = 1'b1;
                        // A low stop bit disarms start detection so a held break yields one word.
                        if (!rx_s_q) armed_d = 1'b0;
                    end else begin
                        sample_d = sample_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (done) begin
            if (!valid_q || data_ready_i) begin
                data_d     = shift_q;
                ferr_d     = !rx_s_q;
                perr_out_d = perr_q;
                valid_d    = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end

        rts_d = !valid_d;
    end

    assign data_o       = data_q;
    assign data_valid_o = valid_q;
    assign frame_err_o  = ferr_q;
    assign parity_err_o = perr_out_q;
    assign overrun_o    = ovr_q;
    assign RTS          = rts_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// Self-checking bench for uart_rx_deser: serial frames driven on RX, received words compared against a frame-level model.
module tb_uart_rx_deser;
    localparam int DW = 8;
    localparam int OS = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          RX;
    logic [19:0]   baud_rate;
    logic          parity_en;
    logic          parity_odd;
    logic [DW-1:0] data_o;
    logic          data_valid_o;
    logic          data_ready_i;
    logic          frame_err_o;
    logic          parity_err_o;
    logic          overrun_o;
    logic          RTS;
    logic          busy_o;

    uart_rx_deser #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
        .clk(clk), .reset(reset), .RX(RX), .baud_rate(baud_rate),
        .parity_en(parity_en), .parity_odd(parity_odd),
        .data_o(data_o), .data_valid_o(data_valid_o), .data_ready_i(data_ready_i),
        .frame_err_o(frame_err_o), .parity_err_o(parity_err_o), .overrun_o(overrun_o),
        .RTS(RTS), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          fe;
        logic          pe;
    } word_t;

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    valid_rise_cyc = 0;
    int    valid_cycles = 0;
    int    ovr_cycles = 0;
    logic  prev_valid = 1'b0;
    word_t got[$];

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        word_t w;
        if (data_valid_o && !prev_valid) begin
            w.d  = data_o;
            w.fe = frame_err_o;
            w.pe = parity_err_o;
            got.push_back(w);
            valid_rise_cyc = cyc;
        end
        if (data_valid_o) valid_cycles++;
        if (overrun_o) ovr_cycles++;
        prev_valid = data_valid_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Parity error means the total count of ones (data + parity bit) has the wrong oddness.
    function automatic logic exp_pe(input logic [DW-1:0] d, input logic pen, input logic pbit, input logic odd);
        int ones;
        ones = $countones(d) + int'(pbit);
        if (!pen) return 1'b0;
        return odd ? (ones % 2 == 0) : (ones % 2 == 1);
    endfunction

    task automatic send_frame(input logic [DW-1:0] d, input logic pen, input logic pbit,
                              input logic stopb, input int bclk, input logic scr);
        RX = 1'b0;
        repeat (10) @(negedge clk);
        if (scr) begin
            baud_rate  = 20'($urandom_range(0, 7));
            parity_en  = 1'($urandom);
            parity_odd = 1'($urandom);
        end
        repeat (bclk - 10) @(negedge clk);
        for (int i = 0; i < DW; i++) begin
            RX = d[i];
            repeat (bclk) @(negedge clk);
        end
        if (pen) begin
            RX = pbit;
            repeat (bclk) @(negedge clk);
        end
        RX = stopb;
        repeat (bclk) @(negedge clk);
        RX = 1'b1;
    endtask

    task automatic expect_word(input string tag, input logic [DW-1:0] d, input logic fe, input logic pe);
        word_t w;
        if (got.size() == 0) begin
            chk({tag, "_present"}, 32'd0, 32'd1);
        end else begin
            w = got.pop_front();
            chk({tag, "_data"}, 32'(w.d), 32'(d));
            chk({tag, "_ferr"}, 32'(w.fe), 32'(fe));
            chk({tag, "_perr"}, 32'(w.pe), 32'(pe));
        end
    endtask

    task automatic run_frame(input string tag, input logic [DW-1:0] d, input logic pen, input logic odd,
                             input logic pbit, input logic stopb, input logic [19:0] b, input logic scr);
        int bclk;
        bclk       = OS * ((b == 20'd0) ? 1 : int'(b));
        baud_rate  = b;
        parity_en  = pen;
        parity_odd = odd;
        got.delete();
        send_frame(d, pen, pbit, stopb, bclk, scr);
        repeat (2 * bclk) @(negedge clk);
        expect_word(tag, d, !stopb, exp_pe(d, pen, pbit, odd));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int lat;
        reset        = 1'b0;
        RX           = 1'b1;
        baud_rate    = 20'd4;
        parity_en    = 1'b0;
        parity_odd   = 1'b0;
        data_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({data_o, data_valid_o, frame_err_o, parity_err_o, overrun_o, RTS, busy_o}),
            32'({8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}));
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Basic 8N1 frame with latency and pulse-width checks
        got.delete();
        valid_cycles = 0;
        ovr_cycles   = 0;
        t0 = cyc;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 64, 1'b0);
        repeat (128) @(negedge clk);
        lat = valid_rise_cyc - t0;
        chk("basic_latency_ok", 32'(lat >= 9 * 64 && lat <= 612), 32'd1);
        chk("basic_valid_width", 32'(valid_cycles), 32'd1);
        chk("basic_no_overrun", 32'(ovr_cycles), 32'd0);
        expect_word("basic", 8'hA5, 1'b0, 1'b0);

        // False start shorter than half a bit
        got.delete();
        RX = 1'b0;
        repeat (20) @(negedge clk);
        chk("false_start_busy", 32'(busy_o), 32'd1);
        RX = 1'b1;
        repeat (40) @(negedge clk);
        chk("false_start_idle", 32'(busy_o), 32'd0);
        repeat (200) @(negedge clk);
        chk("false_start_no_word", 32'(got.size()), 32'd0);

        // Parity, odd mode, 0x3C with both parity bit values
        run_frame("par_p1", 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 20'd4, 1'b0);
        run_frame("par_p0", 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 20'd4, 1'b0);

        // Random frames; config inputs scrambled mid-frame must not matter
        for (int k = 0; k < 10; k++) begin
            run_frame("rand", 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      ($urandom_range(0, 3) != 0), 20'($urandom_range(0, 3)), 1'b1);
        end

        // Break: line held low for 12 bit periods yields exactly one errored word
        baud_rate = 20'd4;
        parity_en = 1'b0;
        got.delete();
        RX = 1'b0;
        repeat (12 * 64) @(negedge clk);
        chk("break_word_count", 32'(got.size()), 32'd1);
        expect_word("break", 8'h00, 1'b1, 1'b0);
        RX = 1'b1;
        repeat (3 * 64) @(negedge clk);
        chk("break_no_repeat", 32'(got.size()), 32'd0);
        run_frame("after_break", 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 20'd4, 1'b0);

        // Overrun and flow control
        data_ready_i = 1'b0;
        run_frame("ovr_first", 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 20'd4, 1'b0);
        chk("hold_valid", 32'(data_valid_o), 32'd1);
        chk("hold_rts", 32'(RTS), 32'd0);
        ovr_cycles = 0;
        got.delete();
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 64, 1'b0);
        repeat (128) @(negedge clk);
        chk("ovr_pulse_cycles", 32'(ovr_cycles), 32'd1);
        chk("ovr_data_kept", 32'(data_o), 32'h11);
        chk("ovr_valid_kept", 32'(data_valid_o), 32'd1);
        chk("ovr_no_new_word", 32'(got.size()), 32'd0);
        data_ready_i = 1'b1;
        @(negedge clk);
        data_ready_i = 1'b0;
        chk("drain_valid", 32'(data_valid_o), 32'd0);
        chk("drain_rts", 32'(RTS), 32'd1);
        data_ready_i = 1'b1;

        // Reset during data bit 3 of 0xFF
        got.delete();
        RX = 1'b0;
        repeat (64) @(negedge clk);
        RX = 1'b1;
        repeat (3 * 64 + 30) @(negedge clk);
        chk("pre_reset_busy", 32'(busy_o), 32'd1);
        reset = 1'b0;
        #1;
        chk("midframe_reset_outputs",
            32'({data_o, data_valid_o, frame_err_o, parity_err_o, overrun_o, RTS, busy_o}),
            32'({8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}));
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (12 * 64) @(negedge clk);
        chk("post_reset_no_word", 32'(got.size()), 32'd0);
        run_frame("post_reset", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 20'd4, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
